// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR: state encoding, width helpers
// and the round/shift/saturate output function.
package fir_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_OUT} state_t;

  // Working width for the output stage; wide enough for any practical WACC.
  localparam int RS_W = 128;

  typedef struct packed {
    logic            sat;
    logic [RS_W-1:0] val;
  } rs_t;

  function automatic int clog2(input int v);
    int r;
    int t;
    r = 0;
    t = v - 1;
    while (t > 0) begin
      r++;
      t = t >> 1;
    end
    return r;
  endfunction

  function automatic int wacc_of(input int win, input int wc, input int ntaps);
    return win + wc + clog2(ntaps);
  endfunction

  // Round half up, arithmetic shift, then clamp to a signed wout-bit range.
  function automatic rs_t round_sat(input logic signed [RS_W-1:0] v,
                                    input int shift, input int wout);
    logic signed [RS_W-1:0] t, hi, lo;
    rs_t r;
    t = v;
    if (shift > 0) t = t + (RS_W'(1) <<< (shift - 1));
    t  = t >>> shift;
    hi = (RS_W'(1) <<< (wout - 1)) - RS_W'(1);
    lo = ~hi;
    r.sat = (t > hi) || (t < lo);
    r.val = (t > hi) ? hi : ((t < lo) ? lo : t);
    return r;
  endfunction

endpackage

// File: rtl/fir_mac_seq_mac.sv
// Signed multiplier feeding a WACC-wide accumulator; load restarts the sum.
module mac_unit #(
  parameter int WIN  = 16,
  parameter int WC   = 18,
  parameter int WACC = 38
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            load,
  input  logic [WIN-1:0]  a,
  input  logic [WC-1:0]   b,
  output logic [WACC-1:0] acc_next
);

  logic signed [WIN+WC-1:0] prod;
  logic signed [WACC-1:0]   pext;
  logic signed [WACC-1:0]   acc;

  assign prod     = $signed(a) * $signed(b);
  assign pext     = WACC'(prod);
  assign acc_next = load ? pext : acc + pext;

  always_ff @(posedge clk) begin
    if (rst)     acc <= '0;
    else if (en) acc <= acc_next;
  end

endmodule

// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR: one MAC per tap over a circular delay line, then a
// round/shift/saturate output stage.
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int WIN   = 16,
  parameter int WC    = 18,
  parameter int NTAPS = 16,
  parameter int WOUT  = 16,
  parameter int SHIFT = 17
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       coef_we,
  input  logic [clog2(NTAPS)-1:0]    coef_addr,
  input  logic [WC-1:0]              coef_din,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIN-1:0]             din,
  output logic                       out_valid,
  output logic [WOUT-1:0]            dout,
  output logic                       sat,
  output logic                       busy
);

  localparam int AW   = clog2(NTAPS);
  localparam int WACC = wacc_of(WIN, WC, NTAPS);

  state_t          state, state_nx;
  logic [AW-1:0]   wr_ptr, newest, k, rd_addr;
  logic [WIN-1:0]  x [NTAPS];
  logic [WC-1:0]   h [NTAPS];
  logic [WACC-1:0] acc_next;
  logic            accept, last_tap, coef_ok;
  rs_t             rs;

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign last_tap = (k == AW'(NTAPS - 1));
  assign coef_ok  = coef_we && (state == ST_IDLE) && (int'(coef_addr) < NTAPS);

  // Walk backwards from the newest sample; NTAPS need not be a power of two.
  always_comb begin
    if (newest >= k) rd_addr = newest - k;
    else             rd_addr = newest + AW'(NTAPS) - k;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (in_valid) state_nx = ST_MAC;
      ST_MAC:  if (last_tap) state_nx = ST_OUT;
      ST_OUT:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  mac_unit #(.WIN(WIN), .WC(WC), .WACC(WACC)) u_mac (
    .clk      (clk),
    .rst      (rst),
    .en       (state == ST_MAC),
    .load     (k == '0),
    .a        (x[rd_addr]),
    .b        (h[k]),
    .acc_next (acc_next)
  );

  // The last tap's sum is rounded straight off the adder so dout is ready in OUT.
  assign rs = round_sat(RS_W'($signed(acc_next)), SHIFT, WOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      newest    <= '0;
      k         <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      sat       <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        x[i] <= '0;
        h[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (coef_ok) h[coef_addr] <= coef_din;
      if (accept) begin
        x[wr_ptr] <= din;
        newest    <= wr_ptr;
        wr_ptr    <= (wr_ptr == AW'(NTAPS - 1)) ? '0 : wr_ptr + AW'(1);
        k         <= '0;
      end
      if (state == ST_MAC) begin
        k <= last_tap ? '0 : k + AW'(1);
        if (last_tap) begin
          out_valid <= 1'b1;
          dout      <= rs.val[WOUT-1:0];
          sat       <= rs.sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed bench for fir_mac_seq: five parameterisations share stimulus buses,
// each with its own valid/write strobe and outputs.
module tb_fir_mac_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic [17:0] coef_din;
  logic [3:0]  coef_addr;
  logic [4:0]  iv, cwe, rdy, ov, satv, bsy;
  logic [35:0] d0;
  logic [15:0] d1, d2;
  logic [7:0]  d3;
  logic [39:0] d4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fir_mac_seq #(.NTAPS(4), .SHIFT(0), .WOUT(36)) u0 (
    .clk(clk), .rst(rst), .coef_we(cwe[0]), .coef_addr(coef_addr[1:0]), .coef_din(coef_din),
    .in_valid(iv[0]), .in_ready(rdy[0]), .din(din), .out_valid(ov[0]), .dout(d0),
    .sat(satv[0]), .busy(bsy[0]));

  fir_mac_seq u1 (
    .clk(clk), .rst(rst), .coef_we(cwe[1]), .coef_addr(coef_addr), .coef_din(coef_din),
    .in_valid(iv[1]), .in_ready(rdy[1]), .din(din), .out_valid(ov[1]), .dout(d1),
    .sat(satv[1]), .busy(bsy[1]));

  fir_mac_seq #(.NTAPS(4), .SHIFT(2), .WOUT(16)) u2 (
    .clk(clk), .rst(rst), .coef_we(cwe[2]), .coef_addr(coef_addr[1:0]), .coef_din(coef_din),
    .in_valid(iv[2]), .in_ready(rdy[2]), .din(din), .out_valid(ov[2]), .dout(d2),
    .sat(satv[2]), .busy(bsy[2]));

  fir_mac_seq #(.NTAPS(4), .SHIFT(0), .WOUT(8)) u3 (
    .clk(clk), .rst(rst), .coef_we(cwe[3]), .coef_addr(coef_addr[1:0]), .coef_din(coef_din),
    .in_valid(iv[3]), .in_ready(rdy[3]), .din(din), .out_valid(ov[3]), .dout(d3),
    .sat(satv[3]), .busy(bsy[3]));

  fir_mac_seq #(.NTAPS(3), .SHIFT(0), .WOUT(40)) u4 (
    .clk(clk), .rst(rst), .coef_we(cwe[4]), .coef_addr(coef_addr[1:0]), .coef_din(coef_din),
    .in_valid(iv[4]), .in_ready(rdy[4]), .din(din), .out_valid(ov[4]), .dout(d4),
    .sat(satv[4]), .busy(bsy[4]));

  function automatic logic signed [63:0] dv(input int id);
    logic signed [63:0] r;
    case (id)
      0:       r = $signed(d0);
      1:       r = $signed(d1);
      2:       r = $signed(d2);
      3:       r = $signed(d3);
      4:       r = $signed(d4);
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input int id);
    for (int n = 0; n < 100 && !rdy[id]; n++) step();
    if (!rdy[id]) chk("in_ready timeout", 0, 1);
  endtask

  task automatic wait_ov(input int id);
    for (int n = 0; n < 100 && !ov[id]; n++) step();
    if (!ov[id]) chk("out_valid timeout", 0, 1);
  endtask

  task automatic load(input int id, input logic [3:0] a, input logic [17:0] v);
    coef_addr = a;
    coef_din  = v;
    cwe[id]   = 1'b1;
    step();
    cwe[id]   = 1'b0;
  endtask

  task automatic send(input int id, input logic [15:0] v,
                      output logic signed [63:0] res, output logic s);
    wait_rdy(id);
    din    = v;
    iv[id] = 1'b1;
    step();
    iv[id] = 1'b0;
    wait_ov(id);
    res = dv(id);
    s   = satv[id];
  endtask

  logic signed [63:0] r, xcur, xprev, expv;
  logic               s, rd;
  int                 acc_cyc, seen;

  initial begin
    rst = 1'b1; iv = '0; cwe = '0; din = '0; coef_din = '0; coef_addr = '0;
    step(); step();
    chk("reset in_ready", {59'd0, rdy}, 64'h1f);
    chk("reset out_valid", {59'd0, ov}, 0);
    chk("reset busy", {59'd0, bsy}, 0);
    chk("reset sat", {59'd0, satv}, 0);
    for (int i = 0; i < 5; i++) chk("reset dout", dv(i), 0);
    rst = 1'b0;
    step();

    // Impulse through h = 1,2,3,4
    for (int i = 0; i < 4; i++) load(0, 4'(i), 18'(i + 1));
    send(0, 16'd1, r, s); chk("impulse y0", r, 1); chk("impulse sat", {63'd0, s}, 0);
    send(0, 16'd0, r, s); chk("impulse y1", r, 2);
    send(0, 16'd0, r, s); chk("impulse y2", r, 3);
    send(0, 16'd0, r, s); chk("impulse y3", r, 4);
    send(0, 16'd0, r, s); chk("impulse y4", r, 0);

    // Back-to-back handshake with h0=h1=0.5 in Q17: y = round((x[n]+x[n-1])/2)
    load(1, 4'd0, 18'd65536);
    load(1, 4'd1, 18'd65536);
    xcur = 0; xprev = 0; acc_cyc = -1;
    din = 16'($urandom); iv[1] = 1'b1;
    for (int cyc = 0; cyc < 90; cyc++) begin
      rd = rdy[1];
      step();
      if (rd) begin
        if (acc_cyc >= 0) chk("accept spacing", 64'(cyc - acc_cyc), 18);
        acc_cyc = cyc;
        xprev = xcur;
        xcur  = $signed(din);
        din   = 16'($urandom);
      end
      if (ov[1]) begin
        chk("accept-to-out latency", 64'(cyc - acc_cyc), 16);
        expv = ((xcur + xprev) * 64'sd65536 + 64'sd65536) >>> 17;
        chk("handshake dout", dv(1), expv);
      end
    end
    iv[1] = 1'b0;

    // Coefficient write together with the accept is used for that sample
    wait_rdy(2);
    coef_addr = 4'd0; coef_din = 18'd1; cwe[2] = 1'b1;
    din = 16'd5; iv[2] = 1'b1;
    step();
    cwe[2] = 1'b0; iv[2] = 1'b0;
    wait_ov(2);
    chk("round 5", dv(2), 1);
    send(2, 16'd6, r, s);  chk("round 6", r, 2);
    send(2, -16'sd6, r, s); chk("round -6", r, -1);
    send(2, -16'sd5, r, s); chk("round -5", r, -1);

    // Saturation with every tap at full scale
    for (int i = 0; i < 4; i++) load(3, 4'(i), 18'h1ffff);
    send(3, 16'sd32767, r, s);  chk("sat pos dout", r, 127);  chk("sat pos flag", {63'd0, s}, 1);
    send(3, -16'sd32768, r, s); chk("sat neg dout", r, -128); chk("sat neg flag", {63'd0, s}, 1);
    for (int i = 0; i < 3; i++) send(3, 16'd0, r, s);
    send(3, 16'd0, r, s); chk("sat flushed dout", r, 0); chk("sat flushed flag", {63'd0, s}, 0);

    // Wrap with NTAPS=3; the out-of-range write must not disturb anything
    load(4, 4'd0, 18'd1);
    load(4, 4'd1, 18'h3fffe);
    load(4, 4'd2, 18'd3);
    load(4, 4'd3, 18'd100);
    for (int i = 1; i <= 7; i++) begin
      send(4, 16'(i), r, s);
      expv = (i == 1) ? 64'sd1 : (i == 2) ? 64'sd0 : 64'(2 * i - 4);
      chk("wrap conv", r, expv);
    end

    // Coefficient write during MAC is dropped
    wait_rdy(1);
    din = 16'd1000; iv[1] = 1'b1;
    step();
    iv[1] = 1'b0;
    step(); step();
    coef_addr = 4'd0; coef_din = 18'd0; cwe[1] = 1'b1;
    step();
    cwe[1] = 1'b0;
    wait_ov(1);
    chk("coef drop mid-mac", dv(1), ((64'sd1000 + xcur) * 64'sd65536 + 64'sd65536) >>> 17);
    send(1, 16'd1000, r, s); chk("coef kept", r, 1000);

    // Reset at MAC tap 2 kills the sample and the history
    wait_rdy(1);
    din = 16'd2000; iv[1] = 1'b1;
    step();
    iv[1] = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    chk("mid-mac rst in_ready", {63'd0, rdy[1]}, 1);
    chk("mid-mac rst busy", {63'd0, bsy[1]}, 0);
    chk("mid-mac rst dout", dv(1), 0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (ov[1]) seen++;
    end
    chk("no out_valid after rst", 64'(seen), 0);
    load(1, 4'd0, 18'd65536);
    load(1, 4'd1, 18'd65536);
    send(1, 16'd20000, r, s); chk("post-rst impulse y0", r, 10000);
    send(1, 16'd0, r, s);     chk("post-rst impulse y1", r, 10000);
    send(1, 16'd0, r, s);     chk("post-rst impulse y2", r, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
